// File: rtl/logic_unit_pipe_if.sv
// Bus between a producer/consumer and the pipelined logic unit.
// The unit itself takes the slave view; whatever feeds it and drains
// results takes the master view. WIDTH and TAG_W must match the unit.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_parity;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_parity, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_parity, out_tag
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit for the execute stage.
// Stage 1 captures the operands, op and tag of an accepted beat; stage 2
// evaluates the selected bitwise op and registers the result together with
// its zero/parity flags and the tag. Valid/ready on both sides, one beat per
// cycle when the consumer keeps up, and at most two beats held while stalled.
module logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_unit_pipe_if.slave bus
);
    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NOR   = 3'b011,
        OP_XNOR  = 3'b100,
        OP_ANDN  = 3'b101,
        OP_ORN   = 3'b110,
        OP_PASSA = 3'b111
    } op_e;

    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_free;
    logic             accept;
    logic             xfer;

    logic [WIDTH-1:0] s2_result;
    logic             s2_zero;
    logic             s2_parity;

    // Stage 2 can take a new beat when it is empty or its beat leaves this
    // cycle. in_ready never looks at in_valid, and out_valid is a register,
    // so there is no combinational path from out_ready back to out_valid.
    assign s2_free      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = s1_valid && s2_free;

    // Stage 1 occupancy: fill on accept, empty when the beat moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (xfer) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 1 payload: only written on accept, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op  <= op_e'(bus.in_op);
            s1_a   <= bus.in_a;
            s1_b   <= bus.in_b;
            s1_tag <= bus.in_tag;
        end
    end

    // Evaluate the selected bitwise op on the stage 1 operands.
    always_comb begin
        s2_result = '0;
        case (s1_op)
            OP_AND:  s2_result = s1_a & s1_b;
            OP_OR:   s2_result = s1_a | s1_b;
            OP_XOR:  s2_result = s1_a ^ s1_b;
            OP_NOR:  s2_result = ~(s1_a | s1_b);
            OP_XNOR: s2_result = ~(s1_a ^ s1_b);
            OP_ANDN: s2_result = s1_a & ~s1_b;
            OP_ORN:  s2_result = s1_a | ~s1_b;
            default: s2_result = s1_a;
        endcase
    end

    // Flags come from the freshly computed result so they register with it.
    always_comb begin
        s2_zero   = (s2_result == '0);
        s2_parity = ^s2_result;
    end

    // Stage 2 output registers: load on transfer, drop valid once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_zero   <= 1'b0;
            bus.out_parity <= 1'b0;
            bus.out_tag    <= '0;
        end else if (xfer) begin
            bus.out_valid  <= 1'b1;
            bus.out_result <= s2_result;
            bus.out_zero   <= s2_zero;
            bus.out_parity <= s2_parity;
            bus.out_tag    <= s1_tag;
        end else if (bus.out_ready) begin
            bus.out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: a 32-bit instance driven through
// directed, backpressure, random-handshake and reset scenarios against a
// queue-based model, plus a 1-bit instance swept over its full truth table.
module tb_logic_unit_pipe;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        int          stamp;
    } beat_t;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        parity;
        logic [4:0]  tag;
    } out_t;

    typedef struct {
        logic r;
        logic z;
        logic p;
        logic t;
    } out1_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic_unit_pipe_if #(.WIDTH(32), .TAG_W(5)) bus32 ();
    logic_unit_pipe_if #(.WIDTH(1),  .TAG_W(1)) bus1 ();

    logic_unit_pipe #(.WIDTH(32), .TAG_W(5)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    logic_unit_pipe #(.WIDTH(1), .TAG_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    beat_t expq[$];
    out_t  got[$];
    out1_t got1[$];
    int    edge_cnt   = 0;
    logic  pend_acc   = 1'b0;
    logic  pend_pop   = 1'b0;
    beat_t pend_beat;
    out_t  pend_out;
    logic  prev_stall = 1'b0;
    out_t  prev_out;
    int    valid_run  = 0;
    int    max_run    = 0;
    logic  ready_mode = 1'b0;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Each op as a truth table indexed by {a_bit, b_bit}.
    function automatic logic [3:0] op_table(input logic [2:0] op);
        case (op)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1110;
            3'd2:    return 4'b0110;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b1001;
            3'd5:    return 4'b0100;
            3'd6:    return 4'b1101;
            default: return 4'b1100;
        endcase
    endfunction

    function automatic logic [31:0] model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [3:0]  tt;
        logic [31:0] r;
        tt = op_table(op);
        for (int i = 0; i < 32; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    function automatic logic model_parity(input logic [31:0] r);
        int ones = 0;
        for (int i = 0; i < 32; i++) ones += int'(r[i]);
        return (ones % 2) != 0;
    endfunction

    // Compare the 32-bit instance against the model away from the active edge.
    always @(negedge clk) begin
        logic        exp_valid;
        logic [31:0] exp_r;
        if (!rst_n) begin
            checkOutput("rst_out_valid", bus32.out_valid, 0);
            checkOutput("rst_out_result", bus32.out_result, 0);
            checkOutput("rst_out_tag", bus32.out_tag, 0);
            pend_acc   = 1'b0;
            pend_pop   = 1'b0;
            prev_stall = 1'b0;
            valid_run  = 0;
        end else begin
            exp_valid = (expq.size() > 0) && (expq[0].stamp < edge_cnt);
            checkOutput("out_valid", bus32.out_valid, exp_valid);
            checkOutput("in_ready", bus32.in_ready, (expq.size() < 2) || bus32.out_ready);
            if (exp_valid && bus32.out_valid) begin
                exp_r = model_op(expq[0].op, expq[0].a, expq[0].b);
                checkOutput("sb_result", bus32.out_result, exp_r);
                checkOutput("sb_zero", bus32.out_zero, exp_r == 32'd0);
                checkOutput("sb_parity", bus32.out_parity, model_parity(exp_r));
                checkOutput("sb_tag", bus32.out_tag, expq[0].tag);
            end
            if (prev_stall) begin
                checkOutput("hold_result", bus32.out_result, prev_out.result);
                checkOutput("hold_tag", bus32.out_tag, prev_out.tag);
                checkOutput("hold_flags", {bus32.out_zero, bus32.out_parity}, {prev_out.zero, prev_out.parity});
            end
            prev_out.result = bus32.out_result;
            prev_out.zero   = bus32.out_zero;
            prev_out.parity = bus32.out_parity;
            prev_out.tag    = bus32.out_tag;
            prev_stall      = bus32.out_valid && !bus32.out_ready;
            if (bus32.out_valid) valid_run++;
            else valid_run = 0;
            if (valid_run > max_run) max_run = valid_run;
            pend_acc       = bus32.in_valid && bus32.in_ready;
            pend_beat.op   = bus32.in_op;
            pend_beat.a    = bus32.in_a;
            pend_beat.b    = bus32.in_b;
            pend_beat.tag  = bus32.in_tag;
            pend_pop       = bus32.out_valid && bus32.out_ready;
            pend_out       = prev_out;
        end
    end

    // Advance the model on each active edge using what was sampled before it.
    always @(posedge clk) begin
        if (rst_n) begin
            edge_cnt++;
            if (pend_pop) begin
                if (expq.size() > 0) void'(expq.pop_front());
                got.push_back(pend_out);
            end
            if (pend_acc) begin
                pend_beat.stamp = edge_cnt;
                expq.push_back(pend_beat);
            end
            pend_acc = 1'b0;
            pend_pop = 1'b0;
        end
    end

    // Reset throws away everything in flight.
    always @(negedge rst_n) begin
        expq.delete();
        pend_acc   = 1'b0;
        pend_pop   = 1'b0;
        prev_stall = 1'b0;
    end

    // Collect beats leaving the 1-bit instance.
    always @(negedge clk) begin
        out1_t o;
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            o.r = bus1.out_result;
            o.z = bus1.out_zero;
            o.p = bus1.out_parity;
            o.t = bus1.out_tag;
            got1.push_back(o);
        end
    end

    // Random consumer readiness while ready_mode is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) bus32.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int   n = 0;
        logic took = 1'b0;
        bus32.in_valid = 1'b1;
        bus32.in_op    = op;
        bus32.in_a     = a;
        bus32.in_b     = b;
        bus32.in_tag   = tag;
        while (!took && n < 200) begin
            @(negedge clk);
            took = bus32.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) checkOutput("accept_timeout", 0, 1);
        bus32.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus32.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while (expq.size() > 0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_timeout", expq.size(), 0);
        idle(2);
    endtask

    // Directed sequence for all scenarios.
    initial begin
        logic [31:0] exp1 [8];
        exp1 = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'h000F_0000,
                 32'h00FF_1234, 32'hF000_0000, 32'hF0FF_1234, 32'hF0F0_1234};
        bus32.in_valid = 1'b0; bus32.in_op = '0; bus32.in_a = '0; bus32.in_b = '0; bus32.in_tag = '0;
        bus32.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_op = '0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_tag = '0;
        bus1.out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset and all eight ops back to back.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", bus32.out_valid, 0);
        checkOutput("reset_zero_parity", {bus32.out_zero, bus32.out_parity}, 0);
        checkOutput("reset_in_ready", bus32.in_ready, 1);
        rst_n = 1'b1;
        got.delete();
        max_run = 0;
        for (int i = 0; i < 8; i++) applyStimulus(3'(i), 32'hF0F0_1234, 32'h0FF0_FFFF, 5'(i));
        waitDrain(50);
        checkOutput("t1_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checkOutput("t1_result", got[i].result, exp1[i]);
            checkOutput("t1_tag", got[i].tag, i);
        end
        checkOutput("t1_valid_run", max_run, 8);

        // Flags.
        got.delete();
        applyStimulus(3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd1);
        applyStimulus(3'b001, 32'h0000_0007, 32'h0, 5'd2);
        waitDrain(50);
        checkOutput("t2_count", got.size(), 2);
        if (got.size() == 2) begin
            checkOutput("t2_xor_result", got[0].result, 0);
            checkOutput("t2_xor_zero", got[0].zero, 1);
            checkOutput("t2_xor_parity", got[0].parity, 0);
            checkOutput("t2_or_result", got[1].result, 7);
            checkOutput("t2_or_zero", got[1].zero, 0);
            checkOutput("t2_or_parity", got[1].parity, 1);
        end

        // Backpressure window while streaming tags 0..9.
        got.delete();
        fork
            begin
                for (int t = 0; t < 10; t++)
                    applyStimulus(3'(t % 8), 32'h1357_0000 + 32'(t), 32'h0F0F_F0F0, 5'(t));
            end
            begin
                for (int c = 0; c < 15; c++) begin
                    bus32.out_ready = !(c >= 3 && c <= 7);
                    @(negedge clk);
                    if (c == 7) begin
                        checkOutput("t3_in_ready_low", bus32.in_ready, 0);
                        checkOutput("t3_out_valid_held", bus32.out_valid, 1);
                    end
                    @(posedge clk);
                    #1;
                end
                bus32.out_ready = 1'b1;
            end
        join
        waitDrain(100);
        checkOutput("t3_count", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) checkOutput("t3_tag_order", got[i].tag, i);

        // Random handshake.
        got.delete();
        ready_mode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            while ($urandom_range(0, 1) == 1) idle(1);
            applyStimulus(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
        end
        ready_mode = 1'b0;
        idle(1);
        bus32.out_ready = 1'b1;
        waitDrain(200);
        checkOutput("t4_count", got.size(), 1000);

        // Asynchronous reset with two beats buffered.
        got.delete();
        bus32.out_ready = 1'b0;
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h1234_5678, 5'd3);
        applyStimulus(3'b001, 32'h0000_00F0, 32'h0000_000F, 5'd4);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("t5_valid_cleared", bus32.out_valid, 0);
        checkOutput("t5_result_cleared", bus32.out_result, 0);
        checkOutput("t5_in_ready", bus32.in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus32.out_ready = 1'b1;
        idle(6);
        checkOutput("t5_no_stale", got.size(), 0);

        // WIDTH=1 truth table sweep.
        got1.delete();
        for (int idx = 0; idx < 32; idx++) begin
            logic [4:0] iv;
            iv = 5'(idx);
            bus1.in_valid = 1'b1;
            bus1.in_op    = iv[4:2];
            bus1.in_a     = iv[1];
            bus1.in_b     = iv[0];
            bus1.in_tag   = iv[1];
            @(posedge clk);
            #1;
        end
        bus1.in_valid = 1'b0;
        idle(4);
        checkOutput("t6_count", got1.size(), 32);
        if (got1.size() == 32) begin
            for (int idx = 0; idx < 32; idx++) begin
                logic [4:0] iv;
                logic [3:0] tt;
                iv = 5'(idx);
                tt = op_table(iv[4:2]);
                checkOutput("t6_result", got1[idx].r, tt[iv[1:0]]);
                checkOutput("t6_flags", {got1[idx].z, got1[idx].p}, {~tt[iv[1:0]], tt[iv[1:0]]});
                checkOutput("t6_tag", got1[idx].t, iv[1]);
            end
            checkOutput("t6_andn_1_0", got1[22].r, 1);
            checkOutput("t6_orn_0_1", got1[25].r, 0);
            checkOutput("t6_nor_0_0", got1[12].r, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: run did not finish, required completion before %0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
